// File: rtl/hazard_ctrl_if.sv
// Hazard unit bundle: pipeline register indices and enables in, forward/stall/flush controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, MemReadE, PCSrcE, PeriphAccessM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemBusy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, MemReadE, PCSrcE, PeriphAccessM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemBusy, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, MemReadE, PCSrcE, PeriphAccessM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemBusy, StallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// and a full-pipeline freeze of WAIT_CYCLES cycles for slow peripheral accesses in M.
module hazard_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEMWAIT, RELEASE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             lw_stall, mem_stall, stall_f;

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) hz.ForwardAE = 2'b01;
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) hz.ForwardBE = 2'b01;
    end

    // In RELEASE the accessing instruction is still in M, so its request is ignored.
    always_comb begin
        lw_stall  = hz.MemReadE && hz.RdE != 5'd0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        mem_stall = (state_q == MEMWAIT) || (state_q == RUN && hz.PeriphAccessM);
    end

    // A frozen pipeline must not lose a taken branch: flushes are suppressed while
    // frozen and PCSrcE, still held in E, acts on the first unfrozen cycle.
    always_comb begin
        stall_f    = mem_stall | lw_stall;
        hz.StallF  = stall_f;
        hz.StallD  = stall_f;
        hz.StallE  = mem_stall;
        hz.StallM  = mem_stall;
        hz.FlushW  = mem_stall;
        hz.FlushD  = !mem_stall && hz.PCSrcE;
        hz.FlushE  = !mem_stall && (lw_stall || hz.PCSrcE);
        hz.MemBusy = mem_stall;
        hz.StallCount = stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                RUN: if (hz.PeriphAccessM) begin
                    state_q <= (WAIT_CYCLES == 1) ? RELEASE : MEMWAIT;
                    cnt_q   <= WAIT_INIT;
                end
                MEMWAIT: begin
                    if (cnt_q == 4'd1) state_q <= RELEASE;
                    cnt_q <= cnt_q - 4'd1;
                end
                RELEASE: state_q <= RUN;
                default: begin
                    state_q <= RUN;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            stall_cnt_q <= '0;
        else if (stall_f && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: forwarding, load-use, branch flush, peripheral freeze,
// freeze-vs-flush priority, reset abort, and stall counter saturation.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) hz0 ();
    hazard_ctrl_if #(.CNT_W(4))  hz1 ();

    hazard_ctrl #(.WAIT_CYCLES(3), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .hz(hz0));
    hazard_ctrl #(.WAIT_CYCLES(1), .CNT_W(4))  dut1 (.clk(clk), .reset(reset), .hz(hz1));

    // {StallF,StallD,StallE,StallM,FlushW,MemBusy,FlushD,FlushE}
    wire [7:0] ctl0 = {hz0.StallF, hz0.StallD, hz0.StallE, hz0.StallM,
                       hz0.FlushW, hz0.MemBusy, hz0.FlushD, hz0.FlushE};
    wire [7:0] ctl1 = {hz1.StallF, hz1.StallD, hz1.StallE, hz1.StallM,
                       hz1.FlushW, hz1.MemBusy, hz1.FlushD, hz1.FlushE};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hz0.Rs1D = 0; hz0.Rs2D = 0; hz0.Rs1E = 0; hz0.Rs2E = 0; hz0.RdE = 0; hz0.RdM = 0; hz0.RdW = 0;
        hz0.RegWriteM = 0; hz0.RegWriteW = 0; hz0.MemReadE = 0; hz0.PCSrcE = 0; hz0.PeriphAccessM = 0;
        hz1.Rs1D = 0; hz1.Rs2D = 0; hz1.Rs1E = 0; hz1.Rs2E = 0; hz1.RdE = 0; hz1.RdM = 0; hz1.RdW = 0;
        hz1.RegWriteM = 0; hz1.RegWriteW = 0; hz1.MemReadE = 0; hz1.PCSrcE = 0; hz1.PeriphAccessM = 0;
    endtask

    // Each cycle window opens 1 unit after the falling edge, 4 units before the rising edge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clr();
        #3;
        chk("rst_ctl", ctl0, 8'h00);
        chk("rst_fwd", {hz0.ForwardAE, hz0.ForwardBE}, 4'b0000);
        chk("rst_cnt", hz0.StallCount, 0);
        nxt(); reset = 1'b1;
        nxt(); chk("idle_ctl", ctl0, 8'h00);

        // forwarding
        hz0.RegWriteM = 1; hz0.RdM = 5; hz0.RegWriteW = 1; hz0.RdW = 5; hz0.Rs1E = 5; hz0.Rs2E = 0;
        #1 chk("fwdA_M_prio", hz0.ForwardAE, 2'b10); chk("fwdB_x0", hz0.ForwardBE, 2'b00);
        hz0.RdM = 0;
        #1 chk("fwdA_W_rd0M", hz0.ForwardAE, 2'b01);
        hz0.Rs2E = 5;
        #1 chk("fwdB_W", hz0.ForwardBE, 2'b01);
        hz0.RdM = 5;
        #1 chk("fwdB_M", hz0.ForwardBE, 2'b10);
        hz0.RegWriteM = 0;
        #1 chk("fwdA_noWM", hz0.ForwardAE, 2'b01);
        hz0.RegWriteW = 0;
        #1 chk("fwdA_none", hz0.ForwardAE, 2'b00);
        clr();

        // load-use and branch flush, cleared before each rising edge
        nxt();
        hz0.MemReadE = 1; hz0.RdE = 7; hz0.Rs2D = 7;
        #1 chk("lw_rs2", ctl0, 8'b1100_0001);
        hz0.RdE = 0;
        #1 chk("lw_rd0", ctl0, 8'h00);
        clr();
        nxt();
        hz0.PCSrcE = 1;
        #1 chk("branch", ctl0, 8'b0000_0011);
        hz0.MemReadE = 1; hz0.RdE = 9; hz0.Rs1D = 9;
        #1 chk("lw_branch", ctl0, 8'b1100_0011);
        clr();
        nxt(); chk("cnt_no_stall", hz0.StallCount, 0);

        // peripheral freeze, WAIT_CYCLES=3
        hz0.PeriphAccessM = 1;
        #1 chk("pw_c0", ctl0, 8'b1111_1100);
        nxt(); chk("pw_c1", ctl0, 8'b1111_1100);
        nxt(); chk("pw_c2", ctl0, 8'b1111_1100);
        nxt(); chk("pw_release", ctl0, 8'h00); chk("pw_cnt", hz0.StallCount, 3);
        hz0.PeriphAccessM = 0;
        nxt(); chk("pw_run", ctl0, 8'h00); chk("pw_cnt_hold", hz0.StallCount, 3);

        // freeze overrides branch/load-use flushes; branch acts in RELEASE
        hz0.PeriphAccessM = 1; hz0.PCSrcE = 1; hz0.MemReadE = 1; hz0.RdE = 4; hz0.Rs1D = 4;
        #1 chk("prio_c0", ctl0, 8'b1111_1100);
        nxt(); hz0.PeriphAccessM = 0;
        #1 chk("prio_c1", ctl0, 8'b1111_1100);
        nxt(); chk("prio_c2", ctl0, 8'b1111_1100);
        nxt(); chk("prio_release", ctl0, 8'b1100_0011);
        clr();
        nxt(); chk("prio_cnt", hz0.StallCount, 6);

        // reset aborts a wait in progress
        hz0.PeriphAccessM = 1;
        nxt(); hz0.PeriphAccessM = 0;
        nxt(); chk("mid_busy", hz0.MemBusy, 1'b1);
        reset = 1'b0;
        #1 chk("abort_busy", hz0.MemBusy, 1'b0); chk("abort_cnt", hz0.StallCount, 0);
        nxt(); reset = 1'b1;
        nxt(); chk("after_rst_ctl", ctl0, 8'h00); chk("after_rst_cnt", hz0.StallCount, 0);
        nxt(); chk("after_rst_ctl2", ctl0, 8'h00);

        // WAIT_CYCLES=1 goes straight to RELEASE
        hz1.PeriphAccessM = 1;
        #1 chk("w1_c0", ctl1, 8'b1111_1100);
        nxt(); chk("w1_release", ctl1, 8'h00);
        hz1.PeriphAccessM = 0;
        nxt(); chk("w1_cnt", hz1.StallCount, 1); chk("w1_run", ctl1, 8'h00);

        // saturation of a 4-bit counter
        hz1.MemReadE = 1; hz1.RdE = 2; hz1.Rs2D = 2;
        for (int i = 0; i < 10; i++) nxt();
        chk("sat_mid", hz1.StallCount, 11);
        for (int i = 0; i < 10; i++) nxt();
        chk("sat_top", hz1.StallCount, 15); chk("sat_ctl", ctl1, 8'b1100_0001);
        clr();
        nxt(); chk("sat_hold", hz1.StallCount, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
